// File: rtl/tbd_pkg.sv
// Shared opcode definitions and instruction-class helpers for the
// fetch/assembler block and the execute stage.
package tbd_pkg;

   localparam logic [2:0] OP_OUT  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_LDI  = 3'b100;
   localparam logic [2:0] OP_AND  = 3'b101;
   localparam logic [2:0] OP_SHLI = 3'b110;
   localparam logic [2:0] OP_XORI = 3'b111;

   // True for opcodes that carry an immediate byte; the fetch block uses
   // this to size the instruction, the execute stage to pick operand B.
   function automatic logic op_has_imm(input logic [2:0] op);
      return (op == OP_ADDI) || (op == OP_LDI) || (op == OP_SHLI) || (op == OP_XORI);
   endfunction

   // Every opcode except OUT writes the register file.
   function automatic logic op_writes_rf(input logic [2:0] op);
      return op != OP_OUT;
   endfunction

   // OUT and LDI leave the condition flags untouched.
   function automatic logic op_sets_flags(input logic [2:0] op);
      return (op != OP_OUT) && (op != OP_LDI);
   endfunction

endpackage

// File: rtl/exec_unit_reg_file.sv
// Register file: NREGS x WIDTH, two combinational read ports, one
// synchronous write port, asynchronous active-low clear of every entry.
module reg_file #(
   parameter int NREGS = 8,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] regs [NREGS];

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         // One register per entry so the whole array clears on reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               regs[gi] <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
               regs[gi] <= wr_data;
            end
         end
      end
   endgenerate

   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/exec_unit.sv
// Two-stage execute unit (E: read/compute, W: writeback/flags/output)
// with a single W->E forwarding path for register-writing ops.
module exec_unit
   import tbd_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       opcode,
   input  logic [2:0]       src_a,
   input  logic [2:0]       src_b,
   input  logic [2:0]       dest,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             flag_z,
   output logic             flag_c
);

   // E/W pipeline registers
   logic             ex_valid;
   logic [2:0]       ex_op;
   logic [2:0]       ex_dest;
   logic [WIDTH-1:0] ex_result;
   logic             ex_c;

   logic [WIDTH-1:0] rd_a, rd_b;
   logic [WIDTH-1:0] opa, opb, opb_sel;
   logic             fwd_a, fwd_b, w_writes;
   logic [WIDTH-1:0] alu_result;
   logic             alu_c;
   logic [2*WIDTH-1:0] shifted;

   assign w_writes = ex_valid && op_writes_rf(ex_op);

   reg_file #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (src_a),
      .rd_data_a (rd_a),
      .rd_addr_b (src_b),
      .rd_data_b (rd_b),
      .wr_en     (w_writes),
      .wr_addr   (ex_dest),
      .wr_data   (ex_result)
   );

   // The array write from W lands at the same edge E samples, so E takes
   // the in-flight result directly when it targets a source register.
   assign fwd_a   = w_writes && (ex_dest == src_a);
   assign fwd_b   = w_writes && (ex_dest == src_b);
   assign opa     = fwd_a ? ex_result : rd_a;
   assign opb     = fwd_b ? ex_result : rd_b;
   assign opb_sel = op_has_imm(opcode) ? imm : opb;

   // ALU: result and carry/borrow for the op currently in E.
   always_comb begin
      alu_result = '0;
      alu_c      = 1'b0;
      shifted    = {{WIDTH{1'b0}}, opa} << imm[2:0];
      case (opcode)
         OP_OUT:           alu_result = opa;
         OP_ADD, OP_ADDI:  {alu_c, alu_result} = {1'b0, opa} + {1'b0, opb_sel};
         // Bit WIDTH of the widened difference is the unsigned borrow.
         OP_SUB:           {alu_c, alu_result} = {1'b0, opa} - {1'b0, opb};
         OP_LDI:           alu_result = imm;
         OP_AND:           alu_result = opa & opb;
         // Bit WIDTH of the widened shift is the last bit shifted out
         // (and is zero for a zero shift amount).
         OP_SHLI: begin
            alu_result = shifted[WIDTH-1:0];
            alu_c      = shifted[WIDTH];
         end
         OP_XORI:          alu_result = opa ^ imm;
         default:          alu_result = '0;
      endcase
   end

   // E stage: capture the computed result for writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_op     <= OP_OUT;
         ex_dest   <= '0;
         ex_result <= '0;
         ex_c      <= 1'b0;
      end else begin
         ex_valid <= op_valid;
         if (op_valid) begin
            ex_op     <= opcode;
            ex_dest   <= dest;
            ex_result <= alu_result;
            ex_c      <= alu_c;
         end
      end
   end

   // W stage: flags and the OUT port; the array write is in reg_file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
      end else begin
         out_valid <= ex_valid && (ex_op == OP_OUT);
         if (ex_valid && (ex_op == OP_OUT)) begin
            out_data <= ex_result;
         end
         if (ex_valid && op_sets_flags(ex_op)) begin
            flag_z <= (ex_result == '0);
            flag_c <= ex_c;
         end
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus random op streams, all
// checked cycle by cycle against a sequential instruction-level model.
module tb_exec_unit;

   localparam int DEPTH = 4096;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       op_valid;
   logic [2:0] opcode, src_a, src_b, dest;
   logic [7:0] imm;
   logic       out_valid;
   logic [7:0] out_data;
   logic       flag_z, flag_c;

   exec_unit #(.NREGS(8), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .opcode    (opcode),
      .src_a     (src_a),
      .src_b     (src_b),
      .dest      (dest),
      .imm       (imm),
      .out_valid (out_valid),
      .out_data  (out_data),
      .flag_z    (flag_z),
      .flag_c    (flag_c)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Architectural model: ops take effect in program order.
   int m_r [8];
   int m_od, m_z, m_c;

   // Expected visible outputs per cycle.
   int exp_ov [DEPTH];
   int exp_od [DEPTH];
   int exp_z  [DEPTH];
   int exp_c  [DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic compare_now();
      int i;
      i = cyc % DEPTH;
      check("out_valid", out_valid, exp_ov[i]);
      check("out_data",  out_data,  exp_od[i]);
      check("flag_z",    flag_z,    exp_z[i]);
      check("flag_c",    flag_c,    exp_c[i]);
      if (out_valid === 1'b1)
         $display("cycle %0d: OUT 0x%02h z=%0d c=%0d", cyc, out_data, flag_z, flag_c);
   endtask

   // Apply one instruction to the model; returns 1 for an OUT.
   function automatic int model_exec(input int op, input int a, input int b,
                                     input int d, input int im);
      int av, bv, r, c, s, sh;
      av = m_r[a];
      bv = m_r[b];
      r  = 0;
      c  = 0;
      case (op)
         0: begin m_od = av; return 1; end
         1: begin s = av + bv; r = s % 256; c = (s > 255) ? 1 : 0; end
         2: begin s = av + im; r = s % 256; c = (s > 255) ? 1 : 0; end
         3: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
         4: begin m_r[d] = im; return 0; end
         5: begin r = av & bv; c = 0; end
         6: begin
            sh = im % 8;
            r  = (av * (1 << sh)) % 256;
            c  = (sh == 0) ? 0 : ((av / (1 << (8 - sh))) % 2);
         end
         default: begin r = av ^ im; c = 0; end
      endcase
      m_r[d] = r;
      m_z    = (r == 0) ? 1 : 0;
      m_c    = c;
      return 0;
   endfunction

   // One clock cycle: drive inputs, predict outputs two cycles ahead,
   // check the current cycle's outputs at the falling edge.
   task automatic step(input bit v, input int op, input int a, input int b,
                       input int d, input int im);
      int ov, i;
      op_valid = v;
      opcode   = op[2:0];
      src_a    = a[2:0];
      src_b    = b[2:0];
      dest     = d[2:0];
      imm      = im[7:0];
      ov = 0;
      if (v) ov = model_exec(op, a, b, d, im);
      i = (cyc + 2) % DEPTH;
      exp_ov[i] = ov;
      exp_od[i] = m_od;
      exp_z[i]  = m_z;
      exp_c[i]  = m_c;
      @(negedge clk);
      compare_now();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 255));
   endtask

   // OUT with stale garbage in the unused fields.
   task automatic out_op(input int a);
      step(1'b1, 0, a, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      op_valid = 1'b0;
      for (int k = 0; k < 8; k++) m_r[k] = 0;
      m_od = 0; m_z = 0; m_c = 0;
      for (int k = 0; k < 3; k++) begin
         exp_ov[(cyc + k) % DEPTH] = 0;
         exp_od[(cyc + k) % DEPTH] = 0;
         exp_z[(cyc + k) % DEPTH]  = 0;
         exp_c[(cyc + k) % DEPTH]  = 0;
      end
      @(negedge clk);
      compare_now();
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
   endtask

   initial begin
      op_valid = 1'b0;
      opcode = '0; src_a = '0; src_b = '0; dest = '0; imm = '0;
      do_reset();

      // Reset state visible through OUT of an untouched register.
      out_op(3);
      idle(3);

      // LDI then idle gap then OUT.
      step(1, 4, 0, 0, 1, 8'hA5);
      idle(3);
      out_op(1);
      idle(2);

      // Back-to-back dependent chain through the forwarding path.
      step(1, 4, 5, 6, 2, 8'h10);
      step(1, 2, 2, 7, 3, 8'h05);
      out_op(3);
      idle(2);

      // ADD carry, SUB zero, SUB borrow.
      step(1, 4, 0, 0, 1, 8'hF0);
      step(1, 4, 0, 0, 2, 8'h20);
      step(1, 1, 1, 2, 3, 0);
      step(1, 3, 1, 1, 4, 0);
      step(1, 3, 2, 1, 5, 0);
      out_op(3);
      out_op(4);
      out_op(5);
      idle(2);

      // Shift carry-out, XOR to zero, AND into r0.
      step(1, 4, 0, 0, 1, 8'h81);
      step(1, 6, 1, 0, 6, 8'hF9);
      step(1, 7, 6, 0, 7, 8'h02);
      step(1, 5, 1, 1, 0, 0);
      out_op(6);
      out_op(7);
      out_op(0);
      step(1, 6, 0, 0, 2, 8'h08);
      idle(2);

      // Reset while an LDI is still in flight.
      step(1, 4, 0, 0, 4, 8'h77);
      do_reset();
      out_op(4);
      idle(3);

      // Random mix with dense back-to-back traffic.
      for (int n = 0; n < 900; n++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
